// File: rtl/ram_slot_requester_pkg.sv
// RAM bus encodings and requester state type.
// Shared by every host and device on the merger.
package RAM;

  localparam logic [1:0] DIN_SIZE_8    = 2'b00;
  localparam logic [1:0] DIN_SIZE_16   = 2'b01;
  localparam logic [1:0] DIN_SIZE_32   = 2'b10;
  localparam logic [1:0] DIN_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    REFRESH
  } slot_req_state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_slot_requester_if.sv
// RAM bus between a host and the expansion merger.
// Idle hosts drive zeros and inactive-high strobes.
interface RAM_IF #(
  parameter int ADDR_BIT_WIDTH = 24
) ();

  logic [ADDR_BIT_WIDTH-1:0] ADDR;
  logic [31:0]               DIN;
  logic [31:0]               DOUT;
  logic [1:0]                DIN_SIZE;
  logic                      OE_n;
  logic                      WE_n;
  logic                      RFSH_n;
  logic                      ACK_n;
  logic                      TIMING;

  modport HOST (
    output ADDR, DIN, DIN_SIZE,
    output OE_n, WE_n, RFSH_n,
    input  DOUT, ACK_n, TIMING
  );

  modport DEVICE (
    input  ADDR, DIN, DIN_SIZE,
    input  OE_n, WE_n, RFSH_n,
    output DOUT, ACK_n, TIMING
  );

endinterface

// File: rtl/ram_slot_requester_slot_counter.sv
// Counts TIMING pulses; flags the pulse that belongs to SLOT.
// All hosts share reset, so every copy stays in lockstep.
module ram_slot_counter
  import RAM::*;
#(
  parameter int SLOT_COUNT = 4,
  parameter int SLOT       = 0
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic TIMING,
  output logic OWN_SLOT
);

  localparam int W = cnt_w(SLOT_COUNT);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(SLOT_COUNT - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_cnt <= '0;
    end else if (TIMING) begin
      r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
    end
  end

  assign OWN_SLOT = TIMING && (r_cnt == W'(SLOT));

endmodule

// File: rtl/ram_slot_requester.sv
// Single-peripheral RAM host: queues one request and runs it,
// or a pending refresh, inside its own TIMING slot.
module ram_slot_requester
  import RAM::*;
#(
  parameter int ADDR_BIT_WIDTH   = 24,
  parameter int SLOT             = 0,
  parameter int SLOT_COUNT       = 4,
  parameter int REFRESH_INTERVAL = 0,
  parameter int TIMEOUT          = 255
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  RAM_IF.HOST                       Ram,
  input  logic                      REQ,
  input  logic                      REQ_WE,
  input  logic [ADDR_BIT_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]               REQ_DIN,
  input  logic [1:0]                REQ_SIZE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic [31:0]               RD_DATA
);

  localparam int TW = cnt_w(TIMEOUT + 1);

  slot_req_state_t r_state, w_next;

  logic                      r_busy, r_we, r_bad;
  logic [ADDR_BIT_WIDTH-1:0] r_addr;
  logic [31:0]               r_din;
  logic [1:0]                r_size;
  logic [TW-1:0]             r_tcnt;
  logic                      r_rfsh_pend;
  logic                      r_done, r_err;
  logic [31:0]               r_rd_data;

  logic [ADDR_BIT_WIDTH-1:0] r_bus_addr, w_bus_addr;
  logic [31:0]               r_bus_din, w_bus_din;
  logic [1:0]                r_bus_size, w_bus_size;
  logic                      r_oe_n, w_oe_n;
  logic                      r_we_n, w_we_n;
  logic                      r_rfsh_n, w_rfsh_n;

  logic                      w_own, w_expire;
  logic                      w_accept, w_bad_in, w_hold;
  logic                      w_ack, w_tout, w_end;
  logic                      w_done, w_err, w_rd_cap;
  logic                      w_we;
  logic [ADDR_BIT_WIDTH-1:0] w_addr;
  logic [31:0]               w_din;
  logic [1:0]                w_size;

  ram_slot_counter #(
    .SLOT_COUNT (SLOT_COUNT),
    .SLOT       (SLOT)
  ) u_slot (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .TIMING   (Ram.TIMING),
    .OWN_SLOT (w_own)
  );

  if (REFRESH_INTERVAL > 0) begin : g_rfsh
    localparam int RW = cnt_w(REFRESH_INTERVAL);
    logic [RW-1:0] r_rcnt;
    assign w_expire = (r_rcnt == RW'(REFRESH_INTERVAL - 1));
    always_ff @(posedge CLK) begin
      if (!RESET_n || w_expire) begin
        r_rcnt <= '0;
      end else begin
        r_rcnt <= r_rcnt + RW'(1);
      end
    end
  end else begin : g_no_rfsh
    assign w_expire = 1'b0;
  end

  // BUSY is low only in IDLE or in a refresh with nothing queued
  assign w_accept = REQ && !r_busy;
  assign w_bad_in = REQ_WE && (REQ_SIZE == DIN_SIZE_RSVD);
  assign w_hold   = r_busy || w_accept;
  assign w_ack    = !Ram.ACK_n;
  assign w_tout   = (r_tcnt == TW'(TIMEOUT));
  assign w_end    = w_ack || w_tout;

  assign w_we   = r_busy ? r_we   : REQ_WE;
  assign w_addr = r_busy ? r_addr : REQ_ADDR;
  assign w_din  = r_busy ? r_din  : REQ_DIN;
  assign w_size = r_busy ? r_size : REQ_SIZE;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_bad_in) begin
          w_next = WAIT;
        end else if (w_own && r_rfsh_pend) begin
          w_next = REFRESH;
        end else if (w_own && w_accept) begin
          w_next = ACCESS;
        end else if (w_accept) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_bad) begin
          w_next = IDLE;
        end else if (w_own && r_rfsh_pend) begin
          w_next = REFRESH;
        end else if (w_own) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        if (w_end) begin
          w_next = IDLE;
        end
      end
      REFRESH: begin
        if (w_end) begin
          w_next = w_hold ? WAIT : IDLE;
        end
      end
    endcase
  end

  // Bus values are decoded from the next state and registered
  always_comb begin
    w_bus_addr = '0;
    w_bus_din  = '0;
    w_bus_size = DIN_SIZE_8;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_rfsh_n   = 1'b1;
    unique case (1'b1)
      (w_next == ACCESS): begin
        w_bus_addr = w_addr;
        w_bus_din  = w_din;
        w_bus_size = w_size;
        w_oe_n     = w_we;
        w_we_n     = !w_we;
      end
      (w_next == REFRESH): begin
        w_rfsh_n = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign w_done   = (r_state == WAIT && r_bad) ||
                    (r_state == ACCESS && w_end);
  assign w_err    = (r_state == WAIT && r_bad) ||
                    (r_state == ACCESS && !w_ack && w_tout);
  assign w_rd_cap = (r_state == ACCESS) && w_ack && !r_we;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_busy      <= 1'b0;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_size      <= DIN_SIZE_8;
      r_tcnt      <= '0;
      r_rfsh_pend <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      r_bus_addr  <= '0;
      r_bus_din   <= '0;
      r_bus_size  <= DIN_SIZE_8;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_rfsh_n    <= 1'b1;
    end else begin
      if (w_accept) begin
        r_busy <= 1'b1;
        r_we   <= REQ_WE;
        r_bad  <= w_bad_in;
        r_addr <= REQ_ADDR;
        r_din  <= REQ_DIN;
        r_size <= REQ_SIZE;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
      if (w_next != r_state) begin
        r_tcnt <= '0;
      end else if (r_state == ACCESS ||
                   r_state == REFRESH) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      // A completed refresh wins over a coincident expiry
      if (r_state == REFRESH && w_end) begin
        r_rfsh_pend <= 1'b0;
      end else if (w_expire) begin
        r_rfsh_pend <= 1'b1;
      end
      r_done <= w_done;
      r_err  <= w_err;
      if (w_rd_cap) begin
        r_rd_data <= Ram.DOUT;
      end
      r_bus_addr <= w_bus_addr;
      r_bus_din  <= w_bus_din;
      r_bus_size <= w_bus_size;
      r_oe_n     <= w_oe_n;
      r_we_n     <= w_we_n;
      r_rfsh_n   <= w_rfsh_n;
    end
  end

  assign Ram.ADDR     = r_bus_addr;
  assign Ram.DIN      = r_bus_din;
  assign Ram.DIN_SIZE = r_bus_size;
  assign Ram.OE_n     = r_oe_n;
  assign Ram.WE_n     = r_we_n;
  assign Ram.RFSH_n   = r_rfsh_n;

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign RD_DATA = r_rd_data;

endmodule

// File: tb/tb_ram_slot_requester.sv
// Directed bench: SLOT=2 of 4, refresh every 100 cycles,
// TIMING every 4th cycle, timeout 16.
module tb_ram_slot_requester;
  import RAM::*;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [23:0] REQ_ADDR = '0;
  logic [31:0] REQ_DIN = '0;
  logic [1:0]  REQ_SIZE = '0;
  logic        BUSY, DONE, ERR;
  logic [31:0] RD_DATA;

  int total = 0;
  int bad = 0;
  int k = 0;

  RAM_IF #(.ADDR_BIT_WIDTH(24)) bus ();

  ram_slot_requester #(
    .ADDR_BIT_WIDTH   (24),
    .SLOT             (2),
    .SLOT_COUNT       (4),
    .REFRESH_INTERVAL (100),
    .TIMEOUT          (16)
  ) dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .Ram      (bus),
    .REQ      (REQ),
    .REQ_WE   (REQ_WE),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DIN  (REQ_DIN),
    .REQ_SIZE (REQ_SIZE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RD_DATA  (RD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h",
             tag, k, obs, exp);
    end
  endtask

  // TIMING pulses are sampled at edges 4,8,12,... after reset
  task automatic cyc();
    @(posedge CLK);
    #1;
    k++;
    bus.TIMING = (k % 4 == 3);
  endtask

  task automatic run_to(input int t);
    while (k < t) cyc();
  endtask

  task automatic req(input logic we, input logic [23:0] a,
                     input logic [31:0] d, input logic [1:0] s);
    REQ      = 1'b1;
    REQ_WE   = we;
    REQ_ADDR = a;
    REQ_DIN  = d;
    REQ_SIZE = s;
  endtask

  initial begin
    bus.TIMING = 1'b0;
    bus.ACK_n  = 1'b1;
    bus.DOUT   = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_n = 1'b1;
    k = 0;
    chk("rst BUSY", BUSY, 0);
    chk("rst DONE", DONE, 0);
    chk("rst ERR", ERR, 0);
    chk("rst RD_DATA", RD_DATA, 0);
    chk("rst ADDR", bus.ADDR, 0);
    chk("rst DIN", bus.DIN, 0);
    chk("rst DIN_SIZE", bus.DIN_SIZE, 0);
    chk("rst OE_n", bus.OE_n, 1);
    chk("rst WE_n", bus.WE_n, 1);
    chk("rst RFSH_n", bus.RFSH_n, 1);

    // read requested right after own slot at edge 12
    run_to(12);
    req(1'b0, 24'h001234, 32'h0, 2'b00);
    cyc();
    REQ = 1'b0;
    chk("rd BUSY", BUSY, 1);
    chk("rd OE_n early", bus.OE_n, 1);
    while (k < 27) begin
      cyc();
      chk("rd idle OE_n", bus.OE_n, 1);
    end
    cyc();
    chk("rd OE_n", bus.OE_n, 0);
    chk("rd WE_n", bus.WE_n, 1);
    chk("rd ADDR", bus.ADDR, 32'h001234);
    bus.ACK_n = 1'b0;
    bus.DOUT  = 32'hDEADBEEF;
    cyc();
    chk("rd DONE", DONE, 1);
    chk("rd ERR", ERR, 0);
    chk("rd RD_DATA", RD_DATA, 32'hDEADBEEF);
    chk("rd BUSY after", BUSY, 0);
    chk("rd OE_n after", bus.OE_n, 1);
    chk("rd ADDR after", bus.ADDR, 0);
    bus.ACK_n = 1'b1;
    bus.DOUT  = '0;
    cyc();
    chk("rd DONE pulse", DONE, 0);
    chk("rd RD_DATA hold", RD_DATA, 32'hDEADBEEF);

    // 16-bit write, accepted edge 31, window at edge 44
    req(1'b1, 24'h000100, 32'h0000A55A, 2'b01);
    cyc();
    REQ = 1'b0;
    run_to(43);
    chk("wr idle WE_n", bus.WE_n, 1);
    cyc();
    chk("wr WE_n", bus.WE_n, 0);
    chk("wr OE_n", bus.OE_n, 1);
    chk("wr DIN_SIZE", bus.DIN_SIZE, 2'b01);
    chk("wr DIN", bus.DIN, 32'h0000A55A);
    chk("wr ADDR", bus.ADDR, 32'h000100);
    bus.DOUT = 32'h11111111;
    repeat (2) begin
      cyc();
      chk("wr hold WE_n", bus.WE_n, 0);
      chk("wr hold DIN_SIZE", bus.DIN_SIZE, 2'b01);
    end
    bus.ACK_n = 1'b0;
    cyc();
    chk("wr DONE", DONE, 1);
    chk("wr ERR", ERR, 0);
    chk("wr ADDR idle", bus.ADDR, 0);
    chk("wr DIN idle", bus.DIN, 0);
    chk("wr DIN_SIZE idle", bus.DIN_SIZE, 0);
    chk("wr WE_n idle", bus.WE_n, 1);
    chk("wr OE_n idle", bus.OE_n, 1);
    chk("wr RFSH_n idle", bus.RFSH_n, 1);
    chk("wr RD_DATA kept", RD_DATA, 32'hDEADBEEF);
    bus.ACK_n = 1'b1;
    bus.DOUT  = '0;
    cyc();
    chk("wr DONE pulse", DONE, 0);

    // reserved write size, accepted edge 49
    req(1'b1, 24'h000200, 32'h12345678, 2'b11);
    cyc();
    REQ = 1'b0;
    chk("bad DONE early", DONE, 0);
    chk("bad WE_n early", bus.WE_n, 1);
    cyc();
    chk("bad DONE", DONE, 1);
    chk("bad ERR", ERR, 1);
    chk("bad WE_n", bus.WE_n, 1);
    chk("bad OE_n", bus.OE_n, 1);
    chk("bad BUSY", BUSY, 0);
    chk("bad RD_DATA", RD_DATA, 32'hDEADBEEF);
    cyc();
    chk("bad DONE pulse", DONE, 0);

    // refresh expires at edge 100 while a read waits
    run_to(94);
    req(1'b0, 24'h000ABC, 32'h0, 2'b00);
    cyc();
    REQ = 1'b0;
    run_to(107);
    chk("rf pre RFSH_n", bus.RFSH_n, 1);
    chk("rf pre OE_n", bus.OE_n, 1);
    cyc();
    chk("rf RFSH_n", bus.RFSH_n, 0);
    chk("rf ADDR", bus.ADDR, 0);
    chk("rf OE_n", bus.OE_n, 1);
    chk("rf WE_n", bus.WE_n, 1);
    chk("rf BUSY", BUSY, 1);
    bus.ACK_n = 1'b0;
    cyc();
    chk("rf end RFSH_n", bus.RFSH_n, 1);
    chk("rf end OE_n", bus.OE_n, 1);
    chk("rf no DONE", DONE, 0);
    chk("rf end BUSY", BUSY, 1);
    bus.ACK_n = 1'b1;
    run_to(123);
    chk("rf wait OE_n", bus.OE_n, 1);
    cyc();
    chk("rf acc OE_n", bus.OE_n, 0);
    chk("rf acc ADDR", bus.ADDR, 32'h000ABC);
    chk("rf acc RFSH_n", bus.RFSH_n, 1);
    bus.ACK_n = 1'b0;
    bus.DOUT  = 32'hCAFEF00D;
    cyc();
    chk("rf acc DONE", DONE, 1);
    chk("rf acc ERR", ERR, 0);
    chk("rf acc RD_DATA", RD_DATA, 32'hCAFEF00D);
    bus.ACK_n = 1'b1;
    bus.DOUT  = '0;

    // no ACK: window opens at edge 140, abort at 157
    cyc();
    req(1'b0, 24'h000200, 32'h0, 2'b00);
    cyc();
    REQ = 1'b0;
    run_to(140);
    chk("to OE_n", bus.OE_n, 0);
    run_to(156);
    chk("to DONE early", DONE, 0);
    chk("to OE_n late", bus.OE_n, 0);
    cyc();
    chk("to DONE", DONE, 1);
    chk("to ERR", ERR, 1);
    chk("to OE_n idle", bus.OE_n, 1);
    chk("to ADDR idle", bus.ADDR, 0);
    chk("to BUSY", BUSY, 0);
    chk("to RD_DATA", RD_DATA, 32'hCAFEF00D);
    cyc();
    chk("to DONE pulse", DONE, 0);

    // reset during ACCESS at edge 172
    req(1'b0, 24'h000300, 32'h0, 2'b00);
    cyc();
    REQ = 1'b0;
    run_to(172);
    chk("mr OE_n", bus.OE_n, 0);
    RESET_n = 1'b0;
    @(posedge CLK);
    #1;
    bus.TIMING = 1'b0;
    chk("mr OE_n rst", bus.OE_n, 1);
    chk("mr ADDR rst", bus.ADDR, 0);
    chk("mr BUSY rst", BUSY, 0);
    chk("mr DONE rst", DONE, 0);
    chk("mr ERR rst", ERR, 0);
    chk("mr RD_DATA rst", RD_DATA, 0);
    @(posedge CLK);
    #1;
    chk("mr DONE hold", DONE, 0);
    RESET_n = 1'b1;
    k = 0;
    req(1'b0, 24'h000400, 32'h0, 2'b00);
    cyc();
    REQ = 1'b0;
    chk("mr BUSY new", BUSY, 1);
    run_to(11);
    chk("mr slot OE_n pre", bus.OE_n, 1);
    cyc();
    chk("mr slot OE_n", bus.OE_n, 0);
    chk("mr slot ADDR", bus.ADDR, 32'h000400);
    bus.ACK_n = 1'b0;
    bus.DOUT  = 32'h0BADF00D;
    cyc();
    chk("mr DONE", DONE, 1);
    chk("mr RD_DATA", RD_DATA, 32'h0BADF00D);
    bus.ACK_n = 1'b1;
    bus.DOUT  = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
